// File: rtl/wb_buf_stage.sv
// Write-back buffer stage: selects the write-back result, queues it in a small FIFO
// and drains entries to the register-file write port, with bypass, retire count and halt.
module wb_buf_stage #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RADDR_W = 3,
  parameter int unsigned DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_sel,
  input  logic               in_lbi,
  input  logic               in_regwrite,
  input  logic               in_halt,
  input  logic [RADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0]  in_alu,
  input  logic [DATA_W-1:0]  in_mem,
  input  logic [DATA_W-1:0]  in_pc2,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic [DATA_W-1:0]  in_opa,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  input  logic               rf_ready,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_waddr,
  output logic [DATA_W-1:0]  fwd_wdata,
  output logic [15:0]        retire_cnt,
  output logic               halted,
  output logic               err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0]  ent_data  [DEPTH];
  logic [RADDR_W-1:0] ent_waddr [DEPTH];
  logic [DEPTH-1:0]   ent_rw;
  logic [DEPTH-1:0]   ent_halt;
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [CNT_W-1:0]   count;

  logic [DATA_W-1:0]  result;
  logic               head_valid;
  logic               push;
  logic               pop;
  logic [PTR_W-1:0]   fwd_idx;

  // Upper operand bits are not part of the SLBI value.
  logic unused_opa;
  assign unused_opa = &{1'b0, in_opa[DATA_W-1:DATA_W-8]};

  // Write-back result select; SLBI shifts the operand left by 8 and merges the immediate byte.
  always_comb begin
    result = '0;
    if (in_lbi) begin
      result = {in_opa[DATA_W-9:0], in_imm[7:0]};
    end else begin
      case (in_sel)
        2'd0:    result = in_alu;
        2'd1:    result = in_mem;
        2'd2:    result = in_pc2;
        default: result = in_imm;
      endcase
    end
  end

  assign head_valid = (count != '0);
  assign in_ready   = (count < CNT_W'(DEPTH)) && !halted;
  assign push       = in_valid && in_ready;
  assign pop        = head_valid && (!ent_rw[rptr] || rf_ready);

  // Head entry drives the write port; outputs depend only on stored state.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (head_valid) begin
      rf_we    = ent_rw[rptr];
      rf_waddr = ent_waddr[rptr];
      rf_wdata = ent_data[rptr];
    end
  end

  // Bypass: walk from the newest entry back toward the head, first regwrite entry wins.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_waddr = '0;
    fwd_wdata = '0;
    fwd_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = wptr - PTR_W'(i + 1);
      if (!fwd_valid && (CNT_W'(i) < count) && ent_rw[fwd_idx]) begin
        fwd_valid = 1'b1;
        fwd_waddr = ent_waddr[fwd_idx];
        fwd_wdata = ent_data[fwd_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      ent_rw     <= '0;
      ent_halt   <= '0;
      retire_cnt <= '0;
      halted     <= 1'b0;
      err        <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_data[i]  <= '0;
        ent_waddr[i] <= '0;
      end
    end else begin
      if (push) begin
        ent_data[wptr]  <= result;
        ent_waddr[wptr] <= in_waddr;
        ent_rw[wptr]    <= in_regwrite;
        ent_halt[wptr]  <= in_halt;
        wptr            <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr       <= rptr + PTR_W'(1);
        retire_cnt <= retire_cnt + 16'd1;
        if (ent_halt[rptr]) halted <= 1'b1;
      end
      // Issue after halt is a protocol violation; the entry itself is dropped.
      if (in_valid && !in_ready && halted) err <= 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_wb_buf_stage.sv
// Directed bench for wb_buf_stage: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_wb_buf_stage;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned DP = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_lbi, in_regwrite, in_halt;
  logic [1:0] in_sel;
  logic [AW-1:0] in_waddr;
  logic [DW-1:0] in_alu, in_mem, in_pc2, in_imm, in_opa;
  logic rf_we, rf_ready, fwd_valid, halted, err;
  logic [AW-1:0] rf_waddr, fwd_waddr;
  logic [DW-1:0] rf_wdata, fwd_wdata;
  logic [15:0] retire_cnt;

  int n_checks = 0;
  int n_fail = 0;

  wb_buf_stage #(.DATA_W(DW), .RADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_lbi(in_lbi), .in_regwrite(in_regwrite), .in_halt(in_halt), .in_waddr(in_waddr),
    .in_alu(in_alu), .in_mem(in_mem), .in_pc2(in_pc2), .in_imm(in_imm), .in_opa(in_opa),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .fwd_valid(fwd_valid), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .retire_cnt(retire_cnt), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] waddr;
    logic          rw;
    logic          halt;
  } ent_t;

  ent_t        mq[$];
  logic        m_halted = 1'b0;
  logic        m_err = 1'b0;
  logic [15:0] m_retire = '0;

  function automatic logic [DW-1:0] m_result();
    if (in_lbi) return DW'(((in_opa & 16'h00FF) << 8) | (in_imm & 16'h00FF));
    case (in_sel)
      2'd0: return in_alu;
      2'd1: return in_mem;
      2'd2: return in_pc2;
      default: return in_imm;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending writes advanced on each clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_halted = 1'b0;
      m_err    = 1'b0;
      m_retire = '0;
    end else begin
      automatic logic rdy = (mq.size() < DP) && !m_halted;
      automatic logic do_pop = (mq.size() > 0) && (!mq[0].rw || rf_ready);
      automatic ent_t e;
      e.data = m_result(); e.waddr = in_waddr; e.rw = in_regwrite; e.halt = in_halt;
      if (in_valid && !rdy && m_halted) m_err = 1'b1;
      if (do_pop) begin
        if (mq[0].halt) m_halted = 1'b1;
        m_retire = m_retire + 16'd1;
        void'(mq.pop_front());
      end
      if (in_valid && rdy) mq.push_back(e);
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    automatic logic          e_fv = 1'b0;
    automatic logic [AW-1:0] e_fa = '0;
    automatic logic [DW-1:0] e_fd = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!e_fv && mq[i].rw) begin
        e_fv = 1'b1; e_fa = mq[i].waddr; e_fd = mq[i].data;
      end
    end
    chk("m_in_ready", 32'(in_ready), 32'((mq.size() < DP) && !m_halted));
    chk("m_rf_we", 32'(rf_we), 32'((mq.size() > 0) && mq[0].rw));
    chk("m_rf_waddr", 32'(rf_waddr), (mq.size() > 0) ? 32'(mq[0].waddr) : 32'd0);
    chk("m_rf_wdata", 32'(rf_wdata), (mq.size() > 0) ? 32'(mq[0].data) : 32'd0);
    chk("m_fwd_valid", 32'(fwd_valid), 32'(e_fv));
    chk("m_fwd_waddr", 32'(fwd_waddr), 32'(e_fa));
    chk("m_fwd_wdata", 32'(fwd_wdata), 32'(e_fd));
    chk("m_retire_cnt", 32'(retire_cnt), 32'(m_retire));
    chk("m_halted", 32'(halted), 32'(m_halted));
    chk("m_err", 32'(err), 32'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic lbi, input logic rw, input logic hlt,
                       input logic [AW-1:0] wa, input logic [DW-1:0] alu);
    in_valid = 1'b1; in_sel = sel; in_lbi = lbi; in_regwrite = rw; in_halt = hlt;
    in_waddr = wa; in_alu = alu;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_lbi = 1'b0; in_regwrite = 1'b0;
    in_halt = 1'b0; in_waddr = '0; in_alu = '0; in_mem = 16'h1111; in_pc2 = 16'h2222;
    in_imm = 16'hFF80; in_opa = 16'h0000; rf_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_retire", 32'(retire_cnt), 32'd0);

    // Single ALU write with the port ready.
    drive(2'd0, 1'b0, 1'b1, 1'b0, 3'd5, 16'h1234);
    tick();
    in_valid = 1'b0;
    chk("alu_rf_we", 32'(rf_we), 32'd1);
    chk("alu_rf_waddr", 32'(rf_waddr), 32'd5);
    chk("alu_rf_wdata", 32'(rf_wdata), 32'h1234);
    tick();
    chk("alu_retire", 32'(retire_cnt), 32'd1);
    chk("alu_drained", 32'(rf_we), 32'd0);

    // SLBI merge.
    in_opa = 16'h00AB; in_imm = 16'h00CD;
    drive(2'd2, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0000);
    tick();
    in_valid = 1'b0;
    chk("slbi_wdata", 32'(rf_wdata), 32'hABCD);
    tick();
    chk("slbi_retire", 32'(retire_cnt), 32'd2);

    // Back-to-back stream through each source select; one entry in flight each cycle.
    in_imm = 16'hFF80;
    for (int s = 0; s < 4; s++) begin
      drive(2'(s), 1'b0, 1'b1, 1'b0, 3'(s + 1), 16'h0A0A);
      tick();
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    chk("stream_sel3_wdata", 32'(rf_wdata), 32'hFF80);
    in_valid = 1'b0;
    tick();
    chk("stream_retire", 32'(retire_cnt), 32'd6);

    // Back-pressure: fill, hold third upstream, then release.
    rf_ready = 1'b0;
    drive(2'd0, 1'b0, 1'b1, 1'b0, 3'd1, 16'hA001);
    tick();
    drive(2'd0, 1'b0, 1'b1, 1'b0, 3'd3, 16'hB002);
    tick();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(2'd0, 1'b0, 1'b1, 1'b0, 3'd4, 16'hC003);
    tick();
    chk("full_hold_ready", 32'(in_ready), 32'd0);
    chk("full_fwd_waddr", 32'(fwd_waddr), 32'd3);
    chk("full_fwd_wdata", 32'(fwd_wdata), 32'hB002);
    chk("full_head_waddr", 32'(rf_waddr), 32'd1);
    rf_ready = 1'b1;
    tick();
    chk("rel1_waddr", 32'(rf_waddr), 32'd3);
    tick();
    chk("rel2_waddr", 32'(rf_waddr), 32'd4);
    chk("rel2_wdata", 32'(rf_wdata), 32'hC003);
    in_valid = 1'b0;
    tick();
    chk("rel_retire", 32'(retire_cnt), 32'd9);

    // Non-writing entry behind a stalled write: bypass shows the older write.
    rf_ready = 1'b0;
    drive(2'd0, 1'b0, 1'b1, 1'b0, 3'd6, 16'h6666);
    tick();
    drive(2'd0, 1'b0, 1'b0, 1'b0, 3'd7, 16'h7777);
    tick();
    in_valid = 1'b0;
    chk("norw_fwd_valid", 32'(fwd_valid), 32'd1);
    chk("norw_fwd_waddr", 32'(fwd_waddr), 32'd6);
    rf_ready = 1'b1;
    tick();
    chk("norw_head_we", 32'(rf_we), 32'd0);
    tick();
    chk("norw_retire", 32'(retire_cnt), 32'd11);

    // Reset with two entries pending.
    rf_ready = 1'b0;
    drive(2'd0, 1'b0, 1'b1, 1'b0, 3'd1, 16'h1001);
    tick();
    drive(2'd0, 1'b0, 1'b1, 1'b0, 3'd2, 16'h2002);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_we", 32'(rf_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_retire", 32'(retire_cnt), 32'd0);
    tick();
    rst = 1'b0;
    rf_ready = 1'b1;
    repeat (3) tick();
    chk("post_rst_we", 32'(rf_we), 32'd0);
    chk("post_rst_retire", 32'(retire_cnt), 32'd0);

    // Halt, then keep issuing.
    drive(2'd0, 1'b0, 1'b1, 1'b1, 3'd7, 16'h7A7A);
    tick();
    drive(2'd0, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0202);
    tick();
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("halt_err", 32'(err), 32'd1);
    chk("halt_retire", 32'(retire_cnt), 32'd2);
    repeat (3) tick();
    chk("halt_retire_stop", 32'(retire_cnt), 32'd2);
    chk("halt_rf_we", 32'(rf_we), 32'd0);
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
